// File: rtl/bbox_iterator.sv
// Walks a latched, sample-aligned bounding box in raster order, emitting one
// candidate sample point per unhalted cycle together with its triangle and color.
module bbox_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [VERTS*AXIS*SIGFIG-1:0]   tri_i,
    input  logic [COLORS*SIGFIG-1:0]       color_i,
    input  logic                           validTri_i,
    input  logic [4*SIGFIG-1:0]            box_i,
    input  logic [3:0]                     subSample_i,
    input  logic                           halt_i,
    output logic                           halt_o,
    output logic [VERTS*AXIS*SIGFIG-1:0]   tri_o,
    output logic [COLORS*SIGFIG-1:0]       color_o,
    output logic [2*SIGFIG-1:0]            sample_o,
    output logic                           validSamp_o
);

    localparam logic [SIGFIG-1:0] STEP_1PX = {{(SIGFIG-1){1'b0}}, 1'b1} << RADIX;

    // halt_o is the externally visible view of this state register.
    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    state_t state, state_next;

    logic [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
    logic [SIGFIG-1:0] samp_x, samp_y, step, step_sel;
    logic signed [SIGFIG:0] x_inc, y_inc, ur_x_ext, ur_y_ext;
    logic x_fits, y_fits, accept;

    always_comb begin
        unique case (subSample_i)
            4'b0100: step_sel = STEP_1PX >> 1;
            4'b0010: step_sel = STEP_1PX >> 2;
            4'b0001: step_sel = STEP_1PX >> 3;
            default: step_sel = STEP_1PX;
        endcase
    end

    // One extra bit keeps x+step / y+step from wrapping near the top of the range.
    assign x_inc    = $signed({samp_x[SIGFIG-1], samp_x}) + $signed({step[SIGFIG-1], step});
    assign y_inc    = $signed({samp_y[SIGFIG-1], samp_y}) + $signed({step[SIGFIG-1], step});
    assign ur_x_ext = $signed({ur_x[SIGFIG-1], ur_x});
    assign ur_y_ext = $signed({ur_y[SIGFIG-1], ur_y});
    assign x_fits   = (x_inc <= ur_x_ext);
    assign y_fits   = (y_inc <= ur_y_ext);
    assign accept   = (state == WAIT) && validTri_i && !halt_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT:    if (accept) state_next = TEST;
            TEST:    if (!halt_i && !x_fits && !y_fits) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        halt_o = (state == TEST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_o       <= '0;
            color_o     <= '0;
            ll_x        <= '0;
            ll_y        <= '0;
            ur_x        <= '0;
            ur_y        <= '0;
            step        <= '0;
            samp_x      <= '0;
            samp_y      <= '0;
            validSamp_o <= 1'b0;
        end else if (accept) begin
            tri_o       <= tri_i;
            color_o     <= color_i;
            ll_x        <= box_i[0*SIGFIG +: SIGFIG];
            ll_y        <= box_i[1*SIGFIG +: SIGFIG];
            ur_x        <= box_i[2*SIGFIG +: SIGFIG];
            ur_y        <= box_i[3*SIGFIG +: SIGFIG];
            step        <= step_sel;
            samp_x      <= box_i[0*SIGFIG +: SIGFIG];
            samp_y      <= box_i[1*SIGFIG +: SIGFIG];
            validSamp_o <= 1'b1;
        end else if (state == TEST && !halt_i) begin
            if (x_fits) begin
                samp_x <= x_inc[SIGFIG-1:0];
            end else if (y_fits) begin
                samp_x <= ll_x;
                samp_y <= y_inc[SIGFIG-1:0];
            end else begin
                validSamp_o <= 1'b0;
            end
        end
    end

    assign sample_o = {samp_y, samp_x};

endmodule

// File: doc/bbox_iterator.md
BBOX_ITERATOR -- requirements
Module: bbox_iterator

Interface
REQ-001 SHALL take parameter SIGFIG, default 24, bits per coordinate/color word (signed fixed point).
REQ-002 SHALL take parameter RADIX, default 10, fraction bits in each word.
REQ-003 SHALL take parameter VERTS, default 3, vertices per micropolygon.
REQ-004 SHALL take parameter AXIS, default 3, axes per vertex (x,y,z).
REQ-005 SHALL take parameter COLORS, default 3, color channels.
REQ-006 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port tri_i  in  VERTS*AXIS*SIGFIG  triangle vertices from bbox stage.
REQ-009 SHALL have port color_i  in  COLORS*SIGFIG  triangle color.
REQ-010 SHALL have port validTri_i  in  1  tri_i/color_i/box_i valid.
REQ-011 SHALL have port box_i  in  4*SIGFIG  {ur_y, ur_x, ll_y, ll_x}, sample-aligned, screen-clamped.
REQ-012 SHALL have port subSample_i  in  4  one-hot step: 1000=1 px, 0100=1/2, 0010=1/4, 0001=1/8.
REQ-013 SHALL have port halt_i  in  1  downstream (hash) stall.
REQ-014 SHALL have port halt_o  out  1  upstream stall; bbox stage holds inputs while high.
REQ-015 SHALL have port tri_o  out  VERTS*AXIS*SIGFIG  latched triangle.
REQ-016 SHALL have port color_o  out  COLORS*SIGFIG  latched color.
REQ-017 SHALL have port sample_o  out  2*SIGFIG  {y, x} current sample point.
REQ-018 SHALL have port validSamp_o  out  1  sample_o/tri_o/color_o valid.

Function
REQ-019 SHALL implement two states: WAIT (idle) and TEST (emitting samples).
REQ-020 step SHALL be 1<<RADIX, 1<<(RADIX-1), 1<<(RADIX-2), 1<<(RADIX-3) for subSample_i 1000/0100/0010/0001; latched at accept.
REQ-021 Accept SHALL occur when state=WAIT, validTri_i=1, halt_i=0; on that edge: latch tri, color, box, step; sample_o<=(ll_y,ll_x); validSamp_o<=1; state<=TEST.
REQ-022 Latency SHALL be one cycle from accept edge to first valid sample.
REQ-023 In TEST with halt_i=0, each edge SHALL advance raster order: x+step if x+step<=ur_x; else x<=ll_x, y<=y+step if y+step<=ur_y.
REQ-024 When x+step>ur_x and y+step>ur_y in TEST with halt_i=0, SHALL set validSamp_o<=0, state<=WAIT (one idle cycle between triangles).
REQ-025 Sample count per triangle SHALL be ((ur_x-ll_x)/step+1)*((ur_y-ll_y)/step+1), one per unhalted cycle.
REQ-026 Comparisons SHALL be signed SIGFIG-bit; x+step and y+step computed at SIGFIG+1 bits, no wrap.
REQ-027 halt_o SHALL equal (state==TEST), combinational from state register.
REQ-028 halt_i=1 SHALL freeze state, sample_o, validSamp_o, tri_o, color_o; no accept in WAIT.
REQ-029 ll==ur box SHALL yield exactly one sample, then WAIT.
REQ-030 validTri_i while halt_o=1 SHALL be ignored (upstream holds it until WAIT).
REQ-031 subSample_i/box_i changes during TEST SHALL not affect the current triangle.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=WAIT, validSamp_o=0, sample_o=0, tri_o=0, color_o=0, halt_o=0.
REQ-033 Reset mid-TEST SHALL abort the triangle; no further samples after rst_n rises until a new accept.

Verification
REQ-034 box ll=(0,0) ur=(2048,1024), step 1 px -> samples (x,y) (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles; halt_o high those 6 cycles.
REQ-035 Same box, subSample 0100 (step 512) -> 5x3=15 samples, last (2048,1024), then validSamp_o=0.
REQ-036 ll=ur=(3072,5120) -> one sample (3072,5120), halt_o high one cycle, back to WAIT.
REQ-037 halt_i high 3 cycles after 2nd sample -> sample_o holds (1024,0) 4 cycles, then sequence resumes with no skip or duplicate.
REQ-038 rst_n low during 3rd sample -> validSamp_o=0, halt_o=0 immediately; next validTri_i accepted normally.
REQ-039 Negative box ll=(-2048,-1024) ur=(-1024,-1024), step 1 px -> samples (-2048,-1024),(-1024,-1024).
